stopwatch_core: RTL and testbench
=================================

STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 Parameter TICK_DIV, default 100000000, clk cycles per count tick (1 Hz at 100 MHz); legal range >=2.
REQ-002 Parameter ADJ_DIV, default 50000000, clk cycles per adjust tick (2 Hz); legal range >=2.
REQ-003 Parameter BLINK_DIV, default 10000000, clk cycles per blink-phase toggle; legal range >=2.
REQ-004 Parameter SCAN_DIV, default 250000, clk cycles per display digit advance; legal range >=2.
REQ-005 Parameter MAX_MIN, default 59, highest minutes value; legal range 1..99.
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 pause_pulse  in  1  single-cycle, already-debounced pause-toggle request.
REQ-009 sel  in  1  adjust field select: 0 = seconds, 1 = minutes; already debounced.
REQ-010 adj  in  1  1 = adjust mode, 0 = count mode; already debounced.
REQ-011 dir  in  1  0 = count up, 1 = count down.
REQ-012 minutes  out  7  current minutes, binary.
REQ-013 seconds  out  6  current seconds, binary, 0..59.
REQ-014 paused  out  1  1 while counting and adjusting are halted.
REQ-015 expired  out  1  sticky flag: a down-count has reached 00:00.
REQ-016 seg  out  7  active-low segments {g,f,e,d,c,b,a} for the currently scanned digit.
REQ-017 an  out  4  active-low one-hot digit enable; an[0] = seconds ones, an[3] = minutes tens.

Function
REQ-018 Each divider SHALL be a free-running counter 0..DIV-1 that emits a one-cycle enable when it equals DIV-1, then wraps to 0; pause and mode do not affect the dividers.
REQ-019 pause_pulse SHALL toggle paused on the following edge; any tick in the same cycle SHALL be processed using the pre-toggle paused value.
REQ-020 When adj=0, paused=0 and dir=0, each count tick SHALL increment seconds; 59 wraps to 0 and carries +1 to minutes; MAX_MIN:59 wraps to 00:00.
REQ-021 When adj=0, paused=0 and dir=1, each count tick SHALL decrement seconds with borrow from minutes; at 00:00 the tick SHALL leave time unchanged and set expired.
REQ-022 A down-count tick that moves 00:01 to 00:00 SHALL set expired on the same edge.
REQ-023 expired SHALL clear on rst, on any pause_pulse, or on any adjust increment.
REQ-024 When adj=1 and paused=0, each adjust tick SHALL increment only the field chosen by sel: seconds 59->0 without carry, minutes MAX_MIN->0; count ticks are ignored.
REQ-025 When paused=1, count and adjust ticks SHALL both be ignored.
REQ-026 Mode inputs (adj, sel, dir) SHALL be sampled every cycle; changing them mid-period SHALL NOT reset any divider.
REQ-027 blink_phase SHALL toggle on each blink tick; when adj=1, paused=0 and blink_phase=1, both digits of the selected field SHALL display blank (seg=7'h7F).
REQ-028 Digit values SHALL be ones = value mod 10 and tens = value / 10, decoded to the standard active-low 0-9 patterns (0 -> 7'h40, 8 -> 7'h00).
REQ-029 The scan index SHALL advance 0->1->2->3->0 on each scan tick; an and seg SHALL be registered and reflect the new index one clk after the tick.

Reset
REQ-030 On rst: minutes=0, seconds=0, paused=0, expired=0, blink_phase=0, scan index=0, all dividers=0, an=4'b1110, seg=7'h40; this applies immediately and asynchronously, including mid-adjust or mid-scan.
REQ-031 After rst deasserts, the first count tick SHALL occur TICK_DIV cycles later.

Verification (TICK_DIV=4, ADJ_DIV=2, BLINK_DIV=3, SCAN_DIV=2, MAX_MIN=59)
REQ-032 Up-count: adj=0, dir=0, run 61 ticks -> minutes=1, seconds=1; preload 59:59 and apply 1 tick -> 00:00.
REQ-033 Down-count: preload 00:02, dir=1, 3 ticks -> 00:01, then 00:00 with expired=1, then 00:00 held with expired=1; a pause_pulse clears expired.
REQ-034 Pause: pause_pulse coincident with a tick while running -> that tick is counted and paused=1; 10 further ticks -> time unchanged; a second pause_pulse -> counting resumes.
REQ-035 Adjust: adj=1, sel=1 from 58:30, 3 adjust ticks -> 59:30, then 00:30, then 01:30, with seconds unchanged; with sel=0 from 00:59, 1 adjust tick -> 00:00 with minutes unchanged.
REQ-036 Blink/scan: adj=1, sel=0 at 12:34 -> an cycles 1110,1101,1011,0111; seg = 7'h19,7'h30,7'h24,7'h79 when blink_phase=0, and the first two are 7'h7F when blink_phase=1.
REQ-037 Asynchronous reset asserted mid-scan at 07:45 -> outputs match REQ-030 before the next clk edge.

Source files
------------

// File: rtl/stopwatch_core.sv
// Minutes:seconds stopwatch with up/down counting, field adjust, pause, expiry flag
// and a four-digit multiplexed seven-segment display driver.
module stopwatch_core #(
  parameter int TICK_DIV  = 100000000,
  parameter int ADJ_DIV   = 50000000,
  parameter int BLINK_DIV = 10000000,
  parameter int SCAN_DIV  = 250000,
  parameter int MAX_MIN   = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pause_pulse,
  input  logic       sel,
  input  logic       adj,
  input  logic       dir,
  output logic [6:0] minutes,
  output logic [5:0] seconds,
  output logic       paused,
  output logic       expired,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam int TICK_W  = $clog2(TICK_DIV);
  localparam int ADJ_W   = $clog2(ADJ_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam int SCAN_W  = $clog2(SCAN_DIV);

  logic [TICK_W-1:0]  tick_cnt;
  logic [ADJ_W-1:0]   adj_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic [SCAN_W-1:0]  scan_cnt;

  logic       count_tick, adj_tick, blink_tick, scan_tick;
  logic       blink_phase;
  logic [1:0] scan_idx;

  logic [6:0] min_nx;
  logic [5:0] sec_nx;
  logic       exp_nx;

  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic [3:0] digit;
  logic       blank;
  logic       blink_on;
  logic [3:0] an_nx;
  logic [6:0] seg_nx;

  assign count_tick = (tick_cnt  == TICK_W'(TICK_DIV - 1));
  assign adj_tick   = (adj_cnt   == ADJ_W'(ADJ_DIV - 1));
  assign blink_tick = (blink_cnt == BLINK_W'(BLINK_DIV - 1));
  assign scan_tick  = (scan_cnt  == SCAN_W'(SCAN_DIV - 1));

  // Dividers free-run regardless of mode or pause so tick spacing never jitters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt    <= '0;
      adj_cnt     <= '0;
      blink_cnt   <= '0;
      scan_cnt    <= '0;
      blink_phase <= 1'b0;
      scan_idx    <= 2'd0;
    end else begin
      tick_cnt  <= count_tick ? '0 : tick_cnt + 1'b1;
      adj_cnt   <= adj_tick   ? '0 : adj_cnt + 1'b1;
      blink_cnt <= blink_tick ? '0 : blink_cnt + 1'b1;
      scan_cnt  <= scan_tick  ? '0 : scan_cnt + 1'b1;
      if (blink_tick) blink_phase <= ~blink_phase;
      if (scan_tick)  scan_idx    <= scan_idx + 2'd1;
    end
  end

  // Time update uses the pre-toggle paused value; a pause request always clears expiry.
  always_comb begin
    min_nx = minutes;
    sec_nx = seconds;
    exp_nx = expired;
    if (!paused) begin
      if (adj) begin
        if (adj_tick) begin
          exp_nx = 1'b0;
          if (sel) min_nx = (minutes == 7'(MAX_MIN)) ? 7'd0 : minutes + 7'd1;
          else     sec_nx = (seconds == 6'd59) ? 6'd0 : seconds + 6'd1;
        end
      end else if (count_tick) begin
        if (!dir) begin
          if (seconds == 6'd59) begin
            sec_nx = 6'd0;
            min_nx = (minutes == 7'(MAX_MIN)) ? 7'd0 : minutes + 7'd1;
          end else begin
            sec_nx = seconds + 6'd1;
          end
        end else if (minutes == 7'd0 && seconds == 6'd0) begin
          exp_nx = 1'b1;
        end else if (seconds == 6'd0) begin
          sec_nx = 6'd59;
          min_nx = minutes - 7'd1;
        end else begin
          sec_nx = seconds - 6'd1;
          if (minutes == 7'd0 && seconds == 6'd1) exp_nx = 1'b1;
        end
      end
    end
    if (pause_pulse) exp_nx = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      minutes <= 7'd0;
      seconds <= 6'd0;
      paused  <= 1'b0;
      expired <= 1'b0;
    end else begin
      minutes <= min_nx;
      seconds <= sec_nx;
      expired <= exp_nx;
      if (pause_pulse) paused <= ~paused;
    end
  end

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  assign sec_ones = 4'(seconds % 6'd10);
  assign sec_tens = 4'(seconds / 6'd10);
  assign min_ones = 4'(minutes % 7'd10);
  assign min_tens = 4'(minutes / 7'd10);
  assign blink_on = adj && !paused && blink_phase;

  always_comb begin
    digit = sec_ones;
    an_nx = 4'b1110;
    blank = 1'b0;
    case (scan_idx)
      2'd0: begin digit = sec_ones; an_nx = 4'b1110; blank = blink_on && !sel; end
      2'd1: begin digit = sec_tens; an_nx = 4'b1101; blank = blink_on && !sel; end
      2'd2: begin digit = min_ones; an_nx = 4'b1011; blank = blink_on &&  sel; end
      default: begin digit = min_tens; an_nx = 4'b0111; blank = blink_on && sel; end
    endcase
    seg_nx = blank ? 7'h7F : seg_decode(digit);
  end

  // Display outputs are registered so the pins never glitch during digit changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= 4'b1110;
      seg <= 7'h40;
    end else begin
      an  <= an_nx;
      seg <= seg_nx;
    end
  end

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: table of count/adjust steps plus hand-written
// sequences for pause, expiry, blink/scan and asynchronous reset.
module tb_stopwatch_core;

  localparam int TICK_DIV  = 4;
  localparam int ADJ_DIV   = 2;
  localparam int BLINK_DIV = 3;
  localparam int SCAN_DIV  = 2;
  localparam int MAX_MIN   = 59;

  logic       clk, rst, pause_pulse, sel, adj, dir;
  logic [6:0] minutes;
  logic [5:0] seconds;
  logic       paused, expired;
  logic [6:0] seg;
  logic [3:0] an;

  stopwatch_core #(
    .TICK_DIV(TICK_DIV), .ADJ_DIV(ADJ_DIV), .BLINK_DIV(BLINK_DIV),
    .SCAN_DIV(SCAN_DIV), .MAX_MIN(MAX_MIN)
  ) dut (
    .clk(clk), .rst(rst), .pause_pulse(pause_pulse), .sel(sel), .adj(adj), .dir(dir),
    .minutes(minutes), .seconds(seconds), .paused(paused), .expired(expired),
    .seg(seg), .an(an)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  int checks;
  int errors;
  logic [6:0] seg_lut [10];

  typedef struct packed {
    logic       adj;
    logic       sel;
    logic       dir;
    logic [7:0] n;
    logic [6:0] exp_min;
    logic [5:0] exp_sec;
    logic       exp_expired;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic a, input logic s, input logic d, input int n,
                              input int m, input int sc, input logic e);
    vec_t v;
    v.adj = a; v.sel = s; v.dir = d; v.n = 8'(n);
    v.exp_min = 7'(m); v.exp_sec = 6'(sc); v.exp_expired = e;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_time(input string name, input int m, input int s, input int p, input int e);
    check({name, " minutes"}, int'(minutes), m);
    check({name, " seconds"}, int'(seconds), s);
    check({name, " paused"},  int'(paused),  p);
    check({name, " expired"}, int'(expired), e);
  endtask

  // Driver tasks: inputs change on negedge, cyc counts posedges since reset release.
  task automatic step();
    @(posedge clk);
    cyc = cyc + 1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; pause_pulse = 1'b0; sel = 1'b0; adj = 1'b0; dir = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic run_ticks(input int div, input int n);
    int seen;
    seen = 0;
    while (seen < n) begin
      step();
      if (cyc % div == 0) seen++;
    end
  endtask

  task automatic pulse_pause(input int div, input bit on_tick);
    while ((((cyc + 1) % div) == 0) != on_tick) step();
    pause_pulse = 1'b1;
    step();
    pause_pulse = 1'b0;
  endtask

  // Scan model with sel=0 and adj=1; display pins lag internal state by one clk.
  task automatic scan_check(input int ncyc, input bit is_paused, input int start_sec, input int mins);
    int m_sec, p_idx, p_sec, digit;
    bit p_blink, blank;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    m_sec = start_sec;
    for (int i = 0; i < ncyc; i++) begin
      p_idx   = (cyc / SCAN_DIV) % 4;
      p_blink = ((cyc / BLINK_DIV) % 2) == 1;
      p_sec   = m_sec;
      step();
      if (!is_paused && (cyc % ADJ_DIV == 0)) m_sec = (m_sec == 59) ? 0 : m_sec + 1;
      case (p_idx)
        0: digit = p_sec % 10;
        1: digit = p_sec / 10;
        2: digit = mins % 10;
        default: digit = mins / 10;
      endcase
      blank   = !is_paused && p_blink && (p_idx < 2);
      exp_an  = ~(4'b0001 << p_idx);
      exp_seg = blank ? 7'h7F : seg_lut[digit];
      check("scan an", int'(an), int'(exp_an));
      check("scan seg", int'(seg), int'(exp_seg));
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    seg_lut[0] = 7'h40; seg_lut[1] = 7'h79; seg_lut[2] = 7'h24; seg_lut[3] = 7'h30;
    seg_lut[4] = 7'h19; seg_lut[5] = 7'h12; seg_lut[6] = 7'h02; seg_lut[7] = 7'h78;
    seg_lut[8] = 7'h00; seg_lut[9] = 7'h10;

    //               adj   sel   dir   n   min sec exp
    vecs[0]  = mk(1'b0, 1'b0, 1'b0, 61,  1,  1, 1'b0);
    vecs[1]  = mk(1'b1, 1'b1, 1'b0, 57, 58,  1, 1'b0);
    vecs[2]  = mk(1'b1, 1'b0, 1'b0, 58, 58, 59, 1'b0);
    vecs[3]  = mk(1'b1, 1'b1, 1'b0,  1, 59, 59, 1'b0);
    vecs[4]  = mk(1'b0, 1'b0, 1'b0,  1,  0,  0, 1'b0);
    vecs[5]  = mk(1'b1, 1'b0, 1'b0,  2,  0,  2, 1'b0);
    vecs[6]  = mk(1'b0, 1'b0, 1'b1,  1,  0,  1, 1'b0);
    vecs[7]  = mk(1'b0, 1'b0, 1'b1,  1,  0,  0, 1'b1);
    vecs[8]  = mk(1'b0, 1'b0, 1'b1,  1,  0,  0, 1'b1);
    vecs[9]  = mk(1'b1, 1'b1, 1'b1,  1,  1,  0, 1'b0);
    vecs[10] = mk(1'b0, 1'b0, 1'b1,  1,  0, 59, 1'b0);
    vecs[11] = mk(1'b1, 1'b0, 1'b0,  1,  0,  0, 1'b0);
    vecs[12] = mk(1'b1, 1'b1, 1'b0, 58, 58,  0, 1'b0);
    vecs[13] = mk(1'b1, 1'b0, 1'b0, 30, 58, 30, 1'b0);
    vecs[14] = mk(1'b1, 1'b1, 1'b0,  1, 59, 30, 1'b0);
    vecs[15] = mk(1'b1, 1'b1, 1'b0,  1,  0, 30, 1'b0);
    vecs[16] = mk(1'b1, 1'b1, 1'b0,  1,  1, 30, 1'b0);
    vecs[17] = mk(1'b0, 1'b0, 1'b0,  1,  1, 31, 1'b0);

    rst = 1'b1; pause_pulse = 1'b0; sel = 1'b0; adj = 1'b0; dir = 1'b0;
    do_reset();

    check_time("reset", 0, 0, 0, 0);
    check("reset an", int'(an), 4'b1110);
    check("reset seg", int'(seg), 7'h40);

    // First count tick lands exactly TICK_DIV clks after reset release
    step(); step(); step();
    check("pre first tick seconds", int'(seconds), 0);
    step();
    check("first tick seconds", int'(seconds), 1);

    do_reset();
    for (int i = 0; i < NV; i++) begin
      adj = vecs[i].adj; sel = vecs[i].sel; dir = vecs[i].dir;
      run_ticks(vecs[i].adj ? ADJ_DIV : TICK_DIV, int'(vecs[i].n));
      check_time($sformatf("vec%0d", i), int'(vecs[i].exp_min), int'(vecs[i].exp_sec),
                 0, int'(vecs[i].exp_expired));
    end

    // Pause coincident with a count tick: tick counted, then frozen
    adj = 1'b0; dir = 1'b0;
    pulse_pause(TICK_DIV, 1'b1);
    check_time("pause on tick", 1, 32, 1, 0);
    run_ticks(TICK_DIV, 10);
    check_time("paused count", 1, 32, 1, 0);
    adj = 1'b1; sel = 1'b0;
    run_ticks(ADJ_DIV, 4);
    check_time("paused adjust", 1, 32, 1, 0);
    adj = 1'b0;
    pulse_pause(TICK_DIV, 1'b0);
    check_time("resume", 1, 32, 0, 0);
    run_ticks(TICK_DIV, 1);
    check_time("resumed count", 1, 33, 0, 0);

    // Down tick at 00:00 sets expiry; a pause request clears it
    do_reset();
    dir = 1'b1;
    run_ticks(TICK_DIV, 1);
    check_time("expire at zero", 0, 0, 0, 1);
    pulse_pause(TICK_DIV, 1'b0);
    check_time("pause clears expired", 0, 0, 1, 0);

    // Blink / scan at 12:34, adjusting seconds
    do_reset();
    adj = 1'b1; sel = 1'b1;
    run_ticks(ADJ_DIV, 12);
    sel = 1'b0;
    run_ticks(ADJ_DIV, 34);
    check_time("preload 12:34", 12, 34, 0, 0);
    pulse_pause(ADJ_DIV, 1'b0);
    check_time("scan paused", 12, 34, 1, 0);
    scan_check(12, 1'b1, 34, 12);
    pulse_pause(ADJ_DIV, 1'b0);
    check_time("scan resumed", 12, 34, 0, 0);
    scan_check(24, 1'b0, 34, 12);

    // Asynchronous reset mid-scan at 07:45
    do_reset();
    adj = 1'b1; sel = 1'b1;
    run_ticks(ADJ_DIV, 7);
    sel = 1'b0;
    run_ticks(ADJ_DIV, 45);
    check_time("preload 07:45", 7, 45, 0, 0);
    adj = 1'b0;
    step(); step(); step();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_time("async reset", 0, 0, 0, 0);
    check("async reset an", int'(an), 4'b1110);
    check("async reset seg", int'(seg), 7'h40);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
